// File: rtl/flash_adc_seq.sv
// Flash ADC sequencer: track/latch timing, thermometer decode with bubble
// detection, 2**AVG_LOG2 averaging and a valid/ready result register.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   ena          block enable; low aborts to IDLE on the next edge
//   start        level, sampled in IDLE to begin one result
//   cont         after OUT, go straight back to TRACK
//   therm        comparator bank outputs, therm[0] = lowest threshold
//   clr_ovr      clears the sticky overrun flag
//   track        sample switch closed
//   latch_en     one-cycle comparator latch strobe
//   data/bubble  averaged result and bubble flag, qualified by valid
//   valid/ready  output handshake
//   overrun      sticky: a result was dropped while valid was held
module flash_adc_seq #(
  parameter int N_COMP     = 15,
  parameter int OUT_W      = 4,
  parameter int SETTLE_CYC = 4,
  parameter int AVG_LOG2   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic              cont,
  input  logic [N_COMP-1:0] therm,
  input  logic              clr_ovr,
  output logic              track,
  output logic              latch_en,
  output logic [OUT_W-1:0]  data,
  output logic              bubble,
  output logic              valid,
  input  logic              ready,
  output logic              overrun
);

  localparam int ACC_W = OUT_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [SET_W-1:0] SET_LAST =
    SET_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRACK,
    S_LATCH,
    S_CAPT,
    S_OUT
  } state_e;

  state_e           state_q, state_d;
  logic [SET_W-1:0] set_q, set_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             bub_q, bub_d;

  logic [OUT_W-1:0] data_q, data_d;
  logic             bout_q, bout_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic [OUT_W-1:0] pop;
  logic             bub_now;
  logic             in_out;
  logic             load;
  logic             drop;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_COMP; i++) begin
      pop = pop + OUT_W'(therm[i]);
    end
  end

  // A clean code is 2**n-1; adding one then clears every set bit.
  assign bub_now = |(therm & (therm + N_COMP'(1)));

  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    bub_d   = bub_q;
    unique case (state_q)
      S_IDLE: begin
        set_d = '0;
        if (start) state_d = S_TRACK;
      end
      S_TRACK: begin
        if (set_q == SET_LAST) begin
          set_d   = '0;
          state_d = S_LATCH;
        end else begin
          set_d = set_q + SET_W'(1);
        end
      end
      S_LATCH: state_d = S_CAPT;
      S_CAPT: begin
        acc_d = acc_q + ACC_W'(pop);
        bub_d = bub_q | bub_now;
        if (cnt_q == CNT_LAST) begin
          state_d = S_OUT;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_TRACK;
        end
      end
      S_OUT: begin
        acc_d   = '0;
        cnt_d   = '0;
        bub_d   = 1'b0;
        state_d = cont ? S_TRACK : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!ena) begin
      state_d = S_IDLE;
      set_d   = '0;
      cnt_d   = '0;
      acc_d   = '0;
      bub_d   = 1'b0;
    end
  end

  assign in_out = ena && (state_q == S_OUT);
  assign load   = in_out && (!valid_q || ready);
  assign drop   = in_out && valid_q && !ready;

  always_comb begin
    data_d  = data_q;
    bout_d  = bout_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (load) begin
      data_d  = OUT_W'(acc_q >> AVG_LOG2);
      bout_d  = bub_q;
      valid_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
    // A fresh drop wins over a simultaneous clear.
    if (drop) begin
      ovr_d = 1'b1;
    end else if (clr_ovr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      set_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      bub_q   <= 1'b0;
      data_q  <= '0;
      bout_q  <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      bub_q   <= bub_d;
      data_q  <= data_d;
      bout_q  <= bout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  // Decoded from the state register so reset drops them at once.
  assign track    = (state_q == S_TRACK);
  assign latch_en = (state_q == S_LATCH);
  assign data     = data_q;
  assign bubble   = bout_q;
  assign valid    = valid_q;
  assign overrun  = ovr_q;

endmodule
